// File: rtl/apb_pkg.sv
// rtl/apb_pkg.sv - shared APB types and defaults
package apb_pkg;

   localparam int APB_ADDR_W = 32;
   localparam int APB_DATA_W = 32;

   typedef enum logic [1:0] {
      IDLE,
      SETUP,
      ACCESS,
      RESP
   } apb_state_t;

   typedef struct packed {
      logic [APB_DATA_W-1:0] rdata;
      logic                  err;
      logic                  timeout;
   } apb_rsp_t;

endpackage

// File: rtl/apb_if.sv
// rtl/apb_if.sv - APB4 peripheral bus with requester/completer views
interface apb_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);
   logic                  PSEL;
   logic                  PENABLE;
   logic                  PWRITE;
   logic [ADDR_W-1:0]     PADDR;
   logic [DATA_W/8-1:0]   PSTRB;
   logic [DATA_W-1:0]     PWDATA;
   logic [DATA_W-1:0]     PRDATA;
   logic                  PREADY;
   logic                  PSLVERR;

   modport master (
      output PSEL, PENABLE, PWRITE, PADDR, PSTRB, PWDATA,
      input  PRDATA, PREADY, PSLVERR
   );

   modport slave (
      input  PSEL, PENABLE, PWRITE, PADDR, PSTRB, PWDATA,
      output PRDATA, PREADY, PSLVERR
   );
endinterface

// File: rtl/apb_timeout_ctr.sv
// rtl/apb_timeout_ctr.sv - counts stalled ACCESS cycles, flags the last allowed one
module apb_timeout_ctr #(
   parameter int TIMEOUT = 255
) (
   input  logic clk,
   input  logic resetn,
   input  logic clear,
   input  logic enable,
   output logic expired
);
   localparam int CW = $clog2(TIMEOUT + 1);
   localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

   logic [CW-1:0] count;

   // Expiry is flagged during the stalled cycle that would bring the count to TIMEOUT.
   assign expired = enable && (count == LAST);

   always_ff @(posedge clk) begin
      if (!resetn) begin
         count <= '0;
      end else if (clear) begin
         count <= '0;
      end else if (enable && !expired) begin
         count <= count + CW'(1);
      end
   end
endmodule

// File: rtl/apb_master.sv
// rtl/apb_master.sv - single-outstanding APB4 requester with timeout and response backpressure
module apb_master
   import apb_pkg::*;
#(
   parameter int ADDR_W  = APB_ADDR_W,
   parameter int DATA_W  = APB_DATA_W,
   parameter int TIMEOUT = 255
) (
   input  logic                PCLK,
   input  logic                PRESETn,
   input  logic                cmd_valid,
   output logic                cmd_ready,
   input  logic [ADDR_W-1:0]   cmd_addr,
   input  logic                cmd_write,
   input  logic [DATA_W-1:0]   cmd_wdata,
   input  logic [DATA_W/8-1:0] cmd_strb,
   output logic                rsp_valid,
   input  logic                rsp_ready,
   output logic [DATA_W-1:0]   rsp_rdata,
   output logic                rsp_err,
   output logic                rsp_timeout,
   apb_if.master               bus
);
   apb_state_t state;
   logic       expired;

   assign cmd_ready = (state == IDLE);

   generate
      if (TIMEOUT > 0) begin : g_timeout
         apb_timeout_ctr #(.TIMEOUT(TIMEOUT)) u_timeout_ctr (
            .clk     (PCLK),
            .resetn  (PRESETn),
            .clear   (state == SETUP),
            .enable  ((state == ACCESS) && !bus.PREADY),
            .expired (expired)
         );
      end else begin : g_no_timeout
         assign expired = 1'b0;
      end
   endgenerate

   always_ff @(posedge PCLK) begin
      if (!PRESETn) begin
         state       <= IDLE;
         bus.PSEL    <= 1'b0;
         bus.PENABLE <= 1'b0;
         bus.PWRITE  <= 1'b0;
         bus.PADDR   <= '0;
         bus.PWDATA  <= '0;
         bus.PSTRB   <= '0;
         rsp_valid   <= 1'b0;
         rsp_rdata   <= '0;
         rsp_err     <= 1'b0;
         rsp_timeout <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (cmd_valid) begin
                  bus.PSEL   <= 1'b1;
                  bus.PWRITE <= cmd_write;
                  bus.PADDR  <= cmd_addr;
                  bus.PWDATA <= cmd_wdata;
                  bus.PSTRB  <= cmd_write ? cmd_strb : '0;
                  state      <= SETUP;
               end
            end
            SETUP: begin
               bus.PENABLE <= 1'b1;
               state       <= ACCESS;
            end
            ACCESS: begin
               // PREADY takes priority over a timeout landing on the same cycle.
               if (bus.PREADY || expired) begin
                  bus.PSEL    <= 1'b0;
                  bus.PENABLE <= 1'b0;
                  rsp_valid   <= 1'b1;
                  rsp_rdata   <= (bus.PREADY && !bus.PWRITE) ? bus.PRDATA : '0;
                  rsp_err     <= bus.PREADY ? bus.PSLVERR : 1'b1;
                  rsp_timeout <= !bus.PREADY;
                  state       <= RESP;
               end
            end
            RESP: begin
               if (rsp_ready) begin
                  rsp_valid <= 1'b0;
                  state     <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_apb_master.sv
// tb/tb_apb_master.sv - directed vector bench for apb_master
module tb_apb_master;
   import apb_pkg::*;

   logic        PCLK = 1'b0;
   logic        PRESETn;
   logic        cmd_valid;
   logic        cmd_ready;
   logic [31:0] cmd_addr;
   logic        cmd_write;
   logic [31:0] cmd_wdata;
   logic [3:0]  cmd_strb;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [31:0] rsp_rdata;
   logic        rsp_err;
   logic        rsp_timeout;

   int total = 0;
   int bad   = 0;

   apb_if #(.ADDR_W(32), .DATA_W(32)) bus ();

   apb_master #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(4)) dut (
      .PCLK        (PCLK),
      .PRESETn     (PRESETn),
      .cmd_valid   (cmd_valid),
      .cmd_ready   (cmd_ready),
      .cmd_addr    (cmd_addr),
      .cmd_write   (cmd_write),
      .cmd_wdata   (cmd_wdata),
      .cmd_strb    (cmd_strb),
      .rsp_valid   (rsp_valid),
      .rsp_ready   (rsp_ready),
      .rsp_rdata   (rsp_rdata),
      .rsp_err     (rsp_err),
      .rsp_timeout (rsp_timeout),
      .bus         (bus)
   );

   always #5 PCLK = ~PCLK;

   typedef struct {
      logic        write;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  strb;
      int          waits;
      logic [31:0] prdata;
      logic        slverr;
      logic [3:0]  exp_strb;
      apb_rsp_t    exp_rsp;
      int          exp_acc;
   } vec_t;

   vec_t vecs[7];

   task automatic tick();
      @(posedge PCLK);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_psel"},      32'(bus.PSEL),    32'd0);
      chk({tag, "_penable"},   32'(bus.PENABLE), 32'd0);
      chk({tag, "_pwrite"},    32'(bus.PWRITE),  32'd0);
      chk({tag, "_paddr"},     bus.PADDR,        32'd0);
      chk({tag, "_pwdata"},    bus.PWDATA,       32'd0);
      chk({tag, "_pstrb"},     32'(bus.PSTRB),   32'd0);
      chk({tag, "_rsp_valid"}, 32'(rsp_valid),   32'd0);
      chk({tag, "_rsp_err"},   32'(rsp_err),     32'd0);
      chk({tag, "_rsp_to"},    32'(rsp_timeout), 32'd0);
      chk({tag, "_rsp_rdata"}, rsp_rdata,        32'd0);
      chk({tag, "_cmd_ready"}, 32'(cmd_ready),   32'd1);
   endtask

   task automatic run_vec(input int idx, input vec_t v);
      int   acc;
      logic stable_ok;
      cmd_valid = 1'b1;
      cmd_write = v.write;
      cmd_addr  = v.addr;
      cmd_wdata = v.wdata;
      cmd_strb  = v.strb;
      chk($sformatf("v%0d_cmd_ready_idle", idx), 32'(cmd_ready), 32'd1);
      tick();
      cmd_valid = 1'b0;
      chk($sformatf("v%0d_setup_psel", idx),    32'(bus.PSEL),    32'd1);
      chk($sformatf("v%0d_setup_penable", idx), 32'(bus.PENABLE), 32'd0);
      chk($sformatf("v%0d_setup_cmd_ready", idx), 32'(cmd_ready), 32'd0);
      chk($sformatf("v%0d_paddr", idx),  bus.PADDR,       v.addr);
      chk($sformatf("v%0d_pwrite", idx), 32'(bus.PWRITE), 32'(v.write));
      chk($sformatf("v%0d_pstrb", idx),  32'(bus.PSTRB),  32'(v.exp_strb));
      if (v.write) chk($sformatf("v%0d_pwdata", idx), bus.PWDATA, v.wdata);
      // PREADY high during SETUP must not end the transfer early
      bus.PREADY  = 1'b1;
      bus.PRDATA  = v.prdata;
      bus.PSLVERR = v.slverr;
      tick();
      acc       = 0;
      stable_ok = 1'b1;
      while (bus.PENABLE === 1'b1 && acc < 50) begin
         acc++;
         if (bus.PSEL !== 1'b1 || bus.PADDR !== v.addr || bus.PSTRB !== v.exp_strb ||
             bus.PWRITE !== v.write)
            stable_ok = 1'b0;
         bus.PREADY = (acc == v.waits + 1);
         tick();
      end
      bus.PREADY = 1'b0;
      chk($sformatf("v%0d_access_cycles", idx), 32'(acc), 32'(v.exp_acc));
      chk($sformatf("v%0d_bus_stable", idx), 32'(stable_ok), 32'd1);
      chk($sformatf("v%0d_rsp_valid", idx), 32'(rsp_valid), 32'd1);
      chk($sformatf("v%0d_resp_psel", idx), 32'(bus.PSEL), 32'd0);
      chk($sformatf("v%0d_rsp_rdata", idx), rsp_rdata, v.exp_rsp.rdata);
      chk($sformatf("v%0d_rsp_err", idx), 32'(rsp_err), 32'(v.exp_rsp.err));
      chk($sformatf("v%0d_rsp_timeout", idx), 32'(rsp_timeout), 32'(v.exp_rsp.timeout));
      tick();
      chk($sformatf("v%0d_rsp_done", idx), 32'(rsp_valid), 32'd0);
      chk($sformatf("v%0d_back_idle", idx), 32'(cmd_ready), 32'd1);
   endtask

   initial begin
      vecs[0] = '{1'b1, 32'h0,  32'hA301200F, 4'hF, 0,  32'hFFFFFFFF, 1'b0, 4'hF, '{32'h0,        1'b0, 1'b0}, 1};
      vecs[1] = '{1'b0, 32'h2,  32'h0,        4'hF, 3,  32'h0070240F, 1'b0, 4'h0, '{32'h0070240F, 1'b0, 1'b0}, 4};
      vecs[2] = '{1'b1, 32'h3,  32'hA030F00F, 4'hF, 0,  32'hFFFFFFFF, 1'b1, 4'hF, '{32'h0,        1'b1, 1'b0}, 1};
      vecs[3] = '{1'b0, 32'h4,  32'h0,        4'hF, 99, 32'hDEADBEEF, 1'b0, 4'h0, '{32'h0,        1'b1, 1'b1}, 4};
      vecs[4] = '{1'b0, 32'h5,  32'h0,        4'h0, 3,  32'h12345678, 1'b0, 4'h0, '{32'h12345678, 1'b0, 1'b0}, 4};
      vecs[5] = '{1'b1, 32'h8,  32'h55AA55AA, 4'h5, 1,  32'hFFFFFFFF, 1'b0, 4'h5, '{32'h0,        1'b0, 1'b0}, 2};
      vecs[6] = '{1'b0, 32'hC,  32'h0,        4'h3, 0,  32'hCAFEF00D, 1'b1, 4'h0, '{32'hCAFEF00D, 1'b1, 1'b0}, 1};

      PRESETn     = 1'b0;
      cmd_valid   = 1'b0;
      cmd_addr    = '0;
      cmd_write   = 1'b0;
      cmd_wdata   = '0;
      cmd_strb    = '0;
      rsp_ready   = 1'b1;
      bus.PREADY  = 1'b0;
      bus.PRDATA  = '0;
      bus.PSLVERR = 1'b0;
      tick();
      tick();
      PRESETn = 1'b1;
      chk_reset_vals("por");
      tick();

      for (int i = 0; i < 7; i++) run_vec(i, vecs[i]);

      // Backpressure: response held for 5 cycles while the next command waits
      cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h10;
      cmd_wdata = 32'h0BADCAFE; cmd_strb = 4'hC;
      rsp_ready = 1'b0;
      tick();
      cmd_write = 1'b0; cmd_addr = 32'h14; cmd_strb = 4'hF;
      bus.PREADY = 1'b1; bus.PSLVERR = 1'b1; bus.PRDATA = 32'h77777777;
      tick();
      tick();
      bus.PREADY = 1'b0; bus.PSLVERR = 1'b0;
      chk("bp_rsp_valid", 32'(rsp_valid), 32'd1);
      for (int i = 0; i < 5; i++) begin
         chk($sformatf("bp_hold%0d_valid", i), 32'(rsp_valid), 32'd1);
         chk($sformatf("bp_hold%0d_fields", i), {rsp_rdata[29:0], rsp_err, rsp_timeout}, {30'd0, 1'b1, 1'b0});
         chk($sformatf("bp_hold%0d_cmd_ready", i), 32'(cmd_ready), 32'd0);
         chk($sformatf("bp_hold%0d_psel", i), 32'(bus.PSEL), 32'd0);
         if (i < 4) tick();
      end
      rsp_ready = 1'b1;
      tick();
      chk("bp_after_hs_psel", 32'(bus.PSEL), 32'd0);
      chk("bp_after_hs_cmd_ready", 32'(cmd_ready), 32'd1);
      tick();
      cmd_valid = 1'b0;
      chk("bp_next_setup_psel", 32'(bus.PSEL), 32'd1);
      chk("bp_next_setup_penable", 32'(bus.PENABLE), 32'd0);
      chk("bp_next_paddr", bus.PADDR, 32'h14);
      bus.PREADY = 1'b1; bus.PRDATA = 32'h00C0FFEE;
      tick();
      tick();
      bus.PREADY = 1'b0;
      chk("bp_next_rsp_valid", 32'(rsp_valid), 32'd1);
      chk("bp_next_rdata", rsp_rdata, 32'h00C0FFEE);
      tick();

      // Reset asserted for one edge in the middle of a waited read
      cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h20;
      cmd_wdata = 32'h11112222; cmd_strb = 4'h3;
      tick();
      cmd_valid = 1'b0;
      bus.PREADY = 1'b0;
      tick();
      tick();
      chk("rst_mid_in_access", 32'(bus.PENABLE), 32'd1);
      PRESETn = 1'b0;
      tick();
      PRESETn = 1'b1;
      chk_reset_vals("rst_mid");
      for (int i = 0; i < 3; i++) begin
         tick();
         chk($sformatf("rst_mid_no_rsp%0d", i), 32'(rsp_valid), 32'd0);
         chk($sformatf("rst_mid_idle_psel%0d", i), 32'(bus.PSEL), 32'd0);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end
endmodule
